// File: rtl/alu_exec_pkg.sv
// Shared constants, decode types and the instruction decoder for alu_exec_unit.
// Optional signed multiply/divide decode is enabled by ALU_EXEC_SIGNED_MD_EN.
package alu_exec_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_SLTI  = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111,
        CTRL_NOR = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        K_ALU  = 3'd0,
        K_MFHI = 3'd1,
        K_MFLO = 3'd2,
        K_MD   = 3'd3,
        K_ILL  = 3'd4
    } kind_e;

    typedef struct packed {
        kind_e     kind;
        alu_ctrl_e ctrl;
        logic      md_div;
        logic      md_signed;
    } decode_t;

    function automatic decode_t decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
        decode_t d;
        d.kind      = K_ALU;
        d.ctrl      = CTRL_ADD;
        d.md_div    = 1'b0;
        d.md_signed = 1'b0;
        case (alu_op)
            ALU_OP_ADD:  d.ctrl = CTRL_ADD;
            ALU_OP_SUB:  d.ctrl = CTRL_SUB;
            ALU_OP_SLTI: d.ctrl = CTRL_SLT;
            default: begin
                case (funct)
                    FUNCT_ADD:   d.ctrl = CTRL_ADD;
                    FUNCT_SUB:   d.ctrl = CTRL_SUB;
                    FUNCT_AND:   d.ctrl = CTRL_AND;
                    FUNCT_OR:    d.ctrl = CTRL_OR;
                    FUNCT_NOR:   d.ctrl = CTRL_NOR;
                    FUNCT_SLT:   d.ctrl = CTRL_SLT;
                    FUNCT_MFHI:  d.kind = K_MFHI;
                    FUNCT_MFLO:  d.kind = K_MFLO;
                    FUNCT_MULTU: d.kind = K_MD;
                    FUNCT_DIVU: begin
                        d.kind   = K_MD;
                        d.md_div = 1'b1;
                    end
`ifdef ALU_EXEC_SIGNED_MD_EN
                    FUNCT_MULT: begin
                        d.kind      = K_MD;
                        d.md_signed = 1'b1;
                    end
                    FUNCT_DIV: begin
                        d.kind      = K_MD;
                        d.md_div    = 1'b1;
                        d.md_signed = 1'b1;
                    end
`endif
                    default:     d.kind = K_ILL;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the multi-cycle controller and the EX-stage unit.
interface alu_exec_if #(
    parameter int WIDTH = 32
) ();
    logic             valid_in;
    logic             ready_in;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid_out;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output valid_in, alu_op, funct, a, b,
        input  ready_in, valid_out, result, zero, err, hi, lo, busy
    );

    modport slave (
        input  valid_in, alu_op, funct, a, b,
        output ready_in, valid_out, result, zero, err, hi, lo, busy
    );
endinterface

// File: rtl/alu_md_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one bit per cycle.
// hi_o/lo_o present the post-step values so the caller can capture them when done_o is high.
module alu_md_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic             run_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;

    // acc holds the product high half / partial remainder; shf holds multiplier bits / quotient.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sum   = '0;
        trial = '0;
        acc_d = acc_q;
        shf_d = shf_q;
        if (div_q) begin
            trial = {acc_q, shf_q[WIDTH-1]};
            if (trial >= {1'b0, m_q}) begin
                acc_d = trial[WIDTH-1:0] - m_q;
                shf_d = {shf_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = trial[WIDTH-1:0];
                shf_d = {shf_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum   = {1'b0, acc_q} + (shf_q[0] ? {1'b0, m_q} : '0);
            acc_d = sum[WIDTH:1];
            shf_d = {sum[0], shf_q[WIDTH-1:1]};
        end
    end

    assign done_o = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign hi_o   = acc_d;
    assign lo_o   = shf_d;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            shf_q <= '0;
            m_q   <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            div_q <= div_i;
            cnt_q <= '0;
            acc_q <= '0;
            shf_q <= div_i ? a_i : b_i;
            m_q   <= div_i ? b_i : a_i;
        end else if (run_q) begin
            acc_q <= acc_d;
            shf_q <= shf_d;
            if (done_o) begin
                run_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with registered single-cycle ops and an iterative HI/LO multiply/divide.
// Define ALU_EXEC_SIGNED_MD_EN to enable signed MULT/DIV on top of the unsigned engine.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_exec_if.slave bus
);

`ifdef ALU_EXEC_SIGNED_MD_EN
    localparam bit SIGNED_MD = 1'b1;
`else
    localparam bit SIGNED_MD = 1'b0;
`endif

    state_e           state_q, state_d;
    decode_t          dec;
    logic             ready, busy;
    logic             accept, md_start, signed_op;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] md_a, md_b;
    logic             md_done;
    logic [WIDTH-1:0] eng_hi, eng_lo, fin_hi, fin_lo;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             valid_out_q, valid_out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_p_q, neg_p_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;

    assign dec       = decode_op(bus.alu_op, bus.funct);
    assign accept    = bus.valid_in && ready;
    assign md_start  = accept && (dec.kind == K_MD);
    assign signed_op = SIGNED_MD && dec.md_signed;

    // Signed forms feed operand magnitudes to the unsigned engine.
    assign md_a = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign md_b = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    alu_md_iter #(.WIDTH(WIDTH)) u_md (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .div_i   (dec.md_div),
        .a_i     (md_a),
        .b_i     (md_b),
        .done_o  (md_done),
        .hi_o    (eng_hi),
        .lo_o    (eng_lo)
    );

    always_comb begin
        case (dec.ctrl)
            CTRL_ADD: alu_res = bus.a + bus.b;
            CTRL_SUB: alu_res = bus.a - bus.b;
            CTRL_AND: alu_res = bus.a & bus.b;
            CTRL_OR:  alu_res = bus.a | bus.b;
            CTRL_NOR: alu_res = ~(bus.a | bus.b);
            CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        fin_hi = eng_hi;
        fin_lo = eng_lo;
        if (neg_p_q) {fin_hi, fin_lo} = -{eng_hi, eng_lo};
        if (neg_q_q) fin_lo = -eng_lo;
        if (neg_r_q) fin_hi = -eng_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (md_start) state_d = dec.md_div ? DIV : MUL;
            MUL,
            DIV:     if (md_done) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == MUL) || (state_q == DIV);
    end

    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        err_d       = err_q;
        valid_out_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        neg_p_d     = neg_p_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        if (accept) begin
            case (dec.kind)
                K_MD: begin
                    // Divide by zero keeps the all-ones quotient; remainder still follows a.
                    neg_p_d = signed_op && !dec.md_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_q_d = signed_op && dec.md_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])
                              && (bus.b != '0);
                    neg_r_d = signed_op && dec.md_div && bus.a[WIDTH-1];
                end
                K_ILL: begin
                    result_d    = '0;
                    zero_d      = 1'b1;
                    err_d       = 1'b1;
                    valid_out_d = 1'b1;
                end
                K_MFHI: begin
                    result_d    = hi_q;
                    zero_d      = (hi_q == '0);
                    err_d       = 1'b0;
                    valid_out_d = 1'b1;
                end
                K_MFLO: begin
                    result_d    = lo_q;
                    zero_d      = (lo_q == '0);
                    err_d       = 1'b0;
                    valid_out_d = 1'b1;
                end
                default: begin
                    result_d    = alu_res;
                    zero_d      = (alu_res == '0);
                    err_d       = 1'b0;
                    valid_out_d = 1'b1;
                end
            endcase
        end
        if (md_done) begin
            hi_d        = fin_hi;
            lo_d        = fin_lo;
            result_d    = fin_lo;
            zero_d      = (fin_lo == '0);
            err_d       = 1'b0;
            valid_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            err_q       <= 1'b0;
            valid_out_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_p_q     <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            valid_out_q <= valid_out_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            neg_p_q     <= neg_p_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
        end
    end

    assign bus.ready_in  = ready;
    assign bus.busy      = busy;
    assign bus.valid_out = valid_out_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expectations, a monitor checks results.
// Signed MULT/DIV vectors follow ALU_EXEC_SIGNED_MD_EN.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_exec_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [W-1:0] result;
        logic       zero;
        logic       err;
        logic       chk_hilo;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic expect_res(input int tag, input logic [W-1:0] res, input logic z,
                              input logic e, input logic chk, input logic [W-1:0] h,
                              input logic [W-1:0] l);
        exp_t x;
        x.tag = tag; x.result = res; x.zero = z; x.err = e;
        x.chk_hilo = chk; x.hi = h; x.lo = l;
        sb.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] aa, input logic [W-1:0] bb);
        int n;
        n = 0;
        while (!bus.ready_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_in wait timeout", 64'd0, 64'd1);
        bus.valid_in = 1'b1;
        bus.alu_op   = op;
        bus.funct    = fn;
        bus.a        = aa;
        bus.b        = bb;
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected valid_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d result", e.tag), 64'(bus.result), 64'(e.result));
                check($sformatf("v%0d zero", e.tag), 64'(bus.zero), 64'(e.zero));
                check($sformatf("v%0d err", e.tag), 64'(bus.err), 64'(e.err));
                if (e.chk_hilo) begin
                    check($sformatf("v%0d hi", e.tag), 64'(bus.hi), 64'(e.hi));
                    check($sformatf("v%0d lo", e.tag), 64'(bus.lo), 64'(e.lo));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_n;
        logic got;
        logic [W-1:0] ill_hi, ill_lo;

        bus.valid_in = 1'b0;
        bus.alu_op   = 2'b00;
        bus.funct    = 6'b0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (3) @(negedge clk);

        check("reset ready_in", 64'(bus.ready_in), 64'd1);
        check("reset valid_out", 64'(bus.valid_out), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset zero", 64'(bus.zero), 64'd1);
        check("reset err", 64'(bus.err), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;

        // Back-to-back single-cycle ops.
        expect_res(1, 32'd12, 1'b0, 1'b0, 1'b0, '0, '0);
        issue(ALU_OP_RTYPE, FUNCT_ADD, 32'd7, 32'd5);
        expect_res(2, 32'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        issue(ALU_OP_SUB, 6'd0, 32'h1234, 32'h1234);
        expect_res(3, 32'd1, 1'b0, 1'b0, 1'b0, '0, '0);
        issue(ALU_OP_SLTI, 6'd0, 32'hFFFF_FFFF, 32'd1);
        expect_res(4, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, '0, '0);
        issue(ALU_OP_RTYPE, FUNCT_SUB, 32'd5, 32'd7);
        expect_res(5, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, '0, '0);
        issue(ALU_OP_RTYPE, FUNCT_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        expect_res(6, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, '0, '0);
        issue(ALU_OP_RTYPE, FUNCT_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        expect_res(7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, '0, '0);
        issue(ALU_OP_RTYPE, FUNCT_NOR, 32'd0, 32'd0);
        expect_res(8, 32'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        issue(ALU_OP_RTYPE, FUNCT_SLT, 32'd1, 32'hFFFF_FFFF);
        expect_res(9, 32'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        issue(ALU_OP_ADD, 6'd0, 32'hFFFF_FFFF, 32'd1);

        // MULTU with valid_in held high (and operands changed) during the iteration.
        expect_res(10, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFE);
        issue(ALU_OP_RTYPE, FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2);
        bus.valid_in = 1'b1;
        bus.alu_op   = ALU_OP_ADD;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
        n = 0; busy_n = 0; got = 1'b0;
        while (n < 100 && !got) begin
            n++;
            if (bus.busy) busy_n++;
            if (bus.valid_out) got = 1'b1;
            else @(negedge clk);
        end
        bus.valid_in = 1'b0;
        check("multu valid_out latency", 64'(n), 64'd33);
        check("multu busy cycles", 64'(busy_n), 64'd32);
        check("done ready_in low", 64'(bus.ready_in), 64'd0);

        expect_res(11, 32'd1, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFE);
        issue(ALU_OP_RTYPE, FUNCT_MFHI, 32'd0, 32'd0);

        expect_res(12, 32'd14, 1'b0, 1'b0, 1'b1, 32'd2, 32'd14);
        issue(ALU_OP_RTYPE, FUNCT_DIVU, 32'd100, 32'd7);
        expect_res(13, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'd9, 32'hFFFF_FFFF);
        issue(ALU_OP_RTYPE, FUNCT_DIVU, 32'd9, 32'd0);
        expect_res(14, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'd9, 32'hFFFF_FFFF);
        issue(ALU_OP_RTYPE, FUNCT_MFLO, 32'd0, 32'd0);
        expect_res(15, 32'd0, 1'b1, 1'b1, 1'b1, 32'd9, 32'hFFFF_FFFF);
        issue(ALU_OP_RTYPE, 6'b111111, 32'd3, 32'd4);

`ifdef ALU_EXEC_SIGNED_MD_EN
        expect_res(16, 32'hFFFF_FFF4, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
        issue(ALU_OP_RTYPE, FUNCT_MULT, 32'hFFFF_FFFD, 32'd4);
        expect_res(17, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(ALU_OP_RTYPE, FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
        ill_hi = 32'hFFFF_FFFF;
        ill_lo = 32'hFFFF_FFFD;
`else
        expect_res(16, 32'd0, 1'b1, 1'b1, 1'b1, 32'd9, 32'hFFFF_FFFF);
        issue(ALU_OP_RTYPE, FUNCT_MULT, 32'hFFFF_FFFD, 32'd4);
        expect_res(17, 32'd0, 1'b1, 1'b1, 1'b1, 32'd9, 32'hFFFF_FFFF);
        issue(ALU_OP_RTYPE, FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
        ill_hi = 32'd9;
        ill_lo = 32'hFFFF_FFFF;
`endif
        expect_res(18, 32'd0, 1'b1, 1'b1, 1'b1, ill_hi, ill_lo);
        issue(ALU_OP_RTYPE, 6'b000001, 32'd0, 32'd0);

        // Reset ten cycles into a MULTU, with a request presented during reset.
        issue(ALU_OP_RTYPE, FUNCT_MULTU, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        check("mid-mul busy", 64'(bus.busy), 64'd1);
        rst          = 1'b1;
        bus.valid_in = 1'b1;
        bus.alu_op   = ALU_OP_ADD;
        bus.a        = 32'd2;
        bus.b        = 32'd3;
        @(negedge clk);
        check("abort valid_out", 64'(bus.valid_out), 64'd0);
        check("abort ready_in", 64'(bus.ready_in), 64'd1);
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort hi", 64'(bus.hi), 64'd0);
        check("abort lo", 64'(bus.lo), 64'd0);
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        repeat (40) @(negedge clk);
        check("post-abort ready_in", 64'(bus.ready_in), 64'd1);
        check("post-abort lo", 64'(bus.lo), 64'd0);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the MIPS ALU control path. Decodes alu_op plus the full 6-bit funct field and executes the operation in one block.
- Single-cycle ops return a registered result with 1-cycle latency.
- Multiply and divide run as an iterative shift-add / restoring-divide state machine that writes HI/LO.
- Sits in the EX stage of the multi-cycle datapath and talks to the controller through a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4; HI and LO are each WIDTH bits).
- CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  request strobe; accepted on an edge where valid_in && ready_in
- ready_in  out  1  high when the unit can accept a request (state IDLE)
- alu_op  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 set-less-than (slti)
- funct  in  6  instruction[5:0]; used only when alu_op=10
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt or immediate)
- valid_out  out  1  one-cycle pulse: result/zero/err are valid
- result  out  WIDTH  registered result
- zero  out  1  result==0, registered with result
- err  out  1  illegal funct; pulses with valid_out
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  mult/div in progress

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready_in=1, valid_out=0, result=0, zero=1, err=0, hi=0, lo=0, busy=0, counter=0. Reset mid-multiply/divide aborts the operation and discards partial HI/LO.
- Decode for alu_op=10, with the full 6-bit funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT (signed)
  - 010000 MFHI, 010010 MFLO
  - 011001 MULTU, 011011 DIVU
  - Any other funct is illegal.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH with no overflow trap. SLT/alu_op=11 yields 1 if $signed(a)<$signed(b), else 0, zero-extended.
- Single-cycle ops (including MFHI/MFLO and illegal): on the accepting edge, result, zero and err are registered. valid_out=1 in the following cycle only. ready_in stays 1, so back-to-back requests give one result per cycle.
- Illegal funct: result=0, zero=1, err=1, valid_out=1. HI/LO unchanged.
- State machine: IDLE -> MUL or DIV on accepting MULTU/DIVU. MUL/DIV -> DONE after WIDTH iterations (counter 0..WIDTH-1). DONE -> IDLE unconditionally.
- In MUL and DIV: ready_in=0, busy=1, valid_in ignored (no queueing).
- MULTU: {hi,lo} = a*b (2*WIDTH-bit unsigned). Operands are latched at acceptance, so a/b may change afterwards.
- DIVU: lo=a/b, hi=a%b (unsigned restoring, one quotient bit per cycle).
- Divide by zero: lo = all ones, hi = a. No err.
- Latency: hi/lo update on the edge entering DONE. In DONE, valid_out=1, result=lo, zero=(lo==0), busy=0, ready_in=0. The next cycle is IDLE with ready_in=1. Total: valid_out is seen WIDTH+1 cycles after the accepting edge.
- MFHI/MFLO issued immediately after DONE return the new values.
- valid_in with rst=1 is ignored.

Optional Feature:
- Macro ALU_EXEC_SIGNED_MD_EN.
- Defined: funct 011000 MULT and 011010 DIV are legal. The signed form takes operand magnitudes, runs the unsigned engine, then fixes signs in DONE.
  - Product is negated if the signs differ.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Same latency as the unsigned forms. Divide by zero behaves as for DIVU.
- Not defined: 011000 and 011010 are illegal (err=1).

Decomposition:
- Package alu_exec_pkg holds:
  - ALU_OP_* 2-bit constants and FUNCT_* 6-bit constants.
  - State enum IDLE/MUL/DIV/DONE.
  - Internal ALU control codes: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1100 nor.
- One natural sub-module: alu_md_iter, the iterative multiply/divide datapath with its counter, driven by start/op and returning done, hi, lo.

Test Plan:
- WIDTH=32 reset, then alu_op=10, funct=100000, a=7, b=5 -> next cycle valid_out=1, result=12, zero=0, err=0.
- alu_op=01, a=b=0x1234 -> result=0, zero=1. alu_op=11, a=0xFFFFFFFF, b=1 -> result=1 (signed compare).
- MULTU a=0xFFFFFFFF, b=2 -> ready_in=0 for 32 cycles; valid_out 33 cycles after accept; hi=1, lo=0xFFFFFFFE. Then MFHI -> result=1.
- DIVU a=100, b=7 -> lo=14, hi=2. DIVU a=9, b=0 -> lo=0xFFFFFFFF, hi=9, err=0.
- funct=111111 -> err=1, result=0, HI/LO unchanged. valid_in held high during MUL is ignored (no extra valid_out).
- Assert rst at cycle 10 of a MULTU -> IDLE next cycle, hi=lo=0, no valid_out. With ALU_EXEC_SIGNED_MD_EN, MULT a=-3, b=4 -> {hi,lo}=-12 (hi=0xFFFFFFFF, lo=0xFFFFFFF4).
